vram_arbiter: RTL and testbench

Owns the 2 KiB CIRAM nametable RAM and shares its single port between two requesters.
- PPU render fetch path: fixed priority, fixed latency.
- CPU $2007 data port: queued, one outstanding request.
Applies cartridge nametable mirroring to map 14-bit PPU addresses to the 11-bit CIRAM address. Sits between the PPU core / CPU-register block and the CIRAM instance.

---
 rtl/vram_pkg.sv | 23 ++
 rtl/vram_arbiter_nt_mirror_map.sv | 34 +++
 rtl/vram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the CIRAM nametable arbiter.
package vram_pkg;

  // Cartridge nametable mirroring arrangement.
  typedef enum logic [1:0] {
    MIR_HORIZ     = 2'd0,
    MIR_VERT      = 2'd1,
    MIR_SINGLE_LO = 2'd2,
    MIR_SINGLE_HI = 2'd3
  } mirror_t;

  // CPU data-port request handling.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RD_WAIT = 2'd2
  } cpu_state_t;

  // Start of the nametable window and start of the palette window.
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

endpackage

// File: rtl/vram_arbiter_nt_mirror_map.sv
// Translates a 14-bit PPU-space address into a CIRAM address using the
// cartridge mirroring mode, and flags whether the address lands in CIRAM.
module nt_mirror_map
  import vram_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 11
) (
  input  logic [AW-1:0] addr_i,
  input  mirror_t       mode_i,
  output logic [CW-1:0] ciram_addr_o,
  output logic          in_range_o
);

  logic nt;

  // Pick which of the two physical 1 KiB pages the address maps onto.
  always_comb begin
    nt = 1'b0;
    unique case (mode_i)
      MIR_HORIZ:     nt = addr_i[11];
      MIR_VERT:      nt = addr_i[10];
      MIR_SINGLE_LO: nt = 1'b0;
      MIR_SINGLE_HI: nt = 1'b1;
    endcase
  end

  assign ciram_addr_o = {nt, addr_i[CW-2:0]};

  // $2000-$3EFF lands in CIRAM; palette space and everything below $2000 do not.
  assign in_range_o = (addr_i[AW-1] == NT_BASE[13]) &&
                      (addr_i[AW-1:8] != PAL_BASE[13:8]);

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single CIRAM port between the fixed-latency PPU fetch path and
// the queued CPU $2007 data port, with a bounded wait for the CPU.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int AW       = 14,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mirror_mode,
  input  logic          ppu_req,
  input  logic [AW-1:0] ppu_addr,
  output logic [7:0]    ppu_rdata,
  output logic          ppu_rvalid,
  output logic          ppu_dropped,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  output logic [CW-1:0] ciram_addr,
  output logic          ciram_we,
  output logic [7:0]    ciram_din,
  input  logic [7:0]    ciram_dout
);

  mirror_t       mode;
  cpu_state_t    state_q, state_d;
  logic [7:0]    wait_q, wait_d;

  logic          req_we_q;
  logic [AW-1:0] req_addr_q;
  logic [7:0]    req_wdata_q;

  logic [CW-1:0] ppu_map, cpu_map;
  logic          ppu_in_range, cpu_in_range;

  logic          latch_en;
  logic          cpu_slot;
  logic          wr_issue, rd_issue;
  logic          ack_d, drop_d;
  logic          rdata_load;
  logic [7:0]    rdata_d;
  logic          ppu_grant;

  logic          s1_valid_q, s1_hit_q;
  logic          s2_valid_q;
  logic [7:0]    s2_data_q;
  logic          rvalid_q, dropped_q, ack_q, we_q;
  logic [7:0]    ppu_rdata_q, cpu_rdata_q, din_q;
  logic [CW-1:0] addr_q;

  assign mode = mirror_t'(mirror_mode);

  nt_mirror_map #(.AW(AW), .CW(CW)) u_ppu_map (
    .addr_i       (ppu_addr),
    .mode_i       (mode),
    .ciram_addr_o (ppu_map),
    .in_range_o   (ppu_in_range)
  );

  nt_mirror_map #(.AW(AW), .CW(CW)) u_cpu_map (
    .addr_i       (req_addr_q),
    .mode_i       (mode),
    .ciram_addr_o (cpu_map),
    .in_range_o   (cpu_in_range)
  );

  // CPU request state and the blocked-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Holds the CPU request captured on entry to PEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 8'h00;
    end else if (latch_en) begin
      req_we_q    <= cpu_we;
      req_addr_q  <= cpu_addr;
      req_wdata_q <= cpu_wdata;
    end
  end

  // Decides who owns the CIRAM port this cycle and what the CPU side does next.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    latch_en   = 1'b0;
    cpu_slot   = 1'b0;
    wr_issue   = 1'b0;
    rd_issue   = 1'b0;
    ack_d      = 1'b0;
    drop_d     = 1'b0;
    rdata_load = 1'b0;
    rdata_d    = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          latch_en = 1'b1;
          wait_d   = 8'd0;
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!ppu_req || (wait_q == 8'(MAX_WAIT))) begin
          cpu_slot = 1'b1;
          drop_d   = ppu_req;
          if (!cpu_in_range) begin
            ack_d      = 1'b1;
            rdata_load = 1'b1;
            rdata_d    = 8'h00;
            state_d    = ST_IDLE;
          end else if (req_we_q) begin
            wr_issue = 1'b1;
            ack_d    = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            rd_issue = 1'b1;
            state_d  = ST_RD_WAIT;
          end
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_RD_WAIT: begin
        ack_d      = 1'b1;
        rdata_load = 1'b1;
        rdata_d    = ciram_dout;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ppu_grant = ppu_req && !cpu_slot;

  // CIRAM port registers; write enable is only ever a single-cycle CPU pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      din_q  <= 8'h00;
    end else begin
      we_q <= 1'b0;
      if (wr_issue) begin
        addr_q <= cpu_map;
        we_q   <= 1'b1;
        din_q  <= req_wdata_q;
      end else if (rd_issue) begin
        addr_q <= cpu_map;
      end else if (ppu_grant && ppu_in_range) begin
        addr_q <= ppu_map;
      end
    end
  end

  // Two-stage PPU return pipeline: capture CIRAM data, then present it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= 8'h00;
      rvalid_q    <= 1'b0;
      ppu_rdata_q <= 8'h00;
      dropped_q   <= 1'b0;
    end else begin
      s1_valid_q  <= ppu_grant;
      s1_hit_q    <= ppu_in_range;
      s2_valid_q  <= s1_valid_q;
      s2_data_q   <= s1_hit_q ? ciram_dout : 8'h00;
      rvalid_q    <= s2_valid_q;
      ppu_rdata_q <= s2_valid_q ? s2_data_q : 8'h00;
      dropped_q   <= drop_d;
    end
  end

  // CPU completion pulse and the held read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      cpu_rdata_q <= 8'h00;
    end else begin
      ack_q <= ack_d;
      if (rdata_load) cpu_rdata_q <= rdata_d;
    end
  end

  assign ppu_rvalid  = rvalid_q;
  assign ppu_rdata   = ppu_rdata_q;
  assign ppu_dropped = dropped_q;
  assign cpu_busy    = (state_q != ST_IDLE);
  assign cpu_ack     = ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ciram_addr  = addr_q;
  assign ciram_we    = we_q;
  assign ciram_din   = din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_vram_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int MAXC     = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mirror_mode = 2'd0;
  logic        ppu_req = 1'b0;
  logic [13:0] ppu_addr = 14'h0;
  logic [7:0]  ppu_rdata;
  logic        ppu_rvalid, ppu_dropped;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = 14'h0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_busy, cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [10:0] ciram_addr;
  logic        ciram_we;
  logic [7:0]  ciram_din;
  logic [7:0]  ciram_dout = 8'h00;

  logic [7:0]  ciram [0:2047] = '{default: 8'h00};

  // Reference contents of CIRAM and scheduled PPU returns, indexed by cycle.
  logic [7:0]  mem [0:2047] = '{default: 8'h00};
  logic        schRv [0:MAXC+3] = '{default: 1'b0};
  logic [7:0]  schRd [0:MAXC+3] = '{default: 8'h00};

  int          nAsserts = 0;
  int          nFails = 0;
  int          cyc = 0;

  int          txnPhase = 0;
  int          latchCyc = 0;
  logic        tWe = 1'b0;
  logic [13:0] tAddr = 14'h0;
  logic [7:0]  tWd = 8'h00;
  int          rdIdx = 0;
  logic [7:0]  curRdata = 8'h00;
  logic [10:0] curAddr = 11'h0;
  logic [7:0]  curDin = 8'h00;
  logic        expAck, expDrop, expWe, expBusy, expRv, rstNow;
  logic [7:0]  expRd;

  always #5 clk = ~clk;

  // Behavioural CIRAM: acts on the falling edge after the address is registered.
  always @(negedge clk) begin
    if (ciram_we) ciram[ciram_addr] <= ciram_din;
    ciram_dout <= ciram[ciram_addr];
  end

  vram_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(14), .CW(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .mirror_mode (mirror_mode),
    .ppu_req     (ppu_req),
    .ppu_addr    (ppu_addr),
    .ppu_rdata   (ppu_rdata),
    .ppu_rvalid  (ppu_rvalid),
    .ppu_dropped (ppu_dropped),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_busy    (cpu_busy),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .ciram_addr  (ciram_addr),
    .ciram_we    (ciram_we),
    .ciram_din   (ciram_din),
    .ciram_dout  (ciram_dout)
  );

  function automatic bit inRange(input logic [13:0] a);
    int av;
    av = int'(a);
    return (av >= 'h2000) && (av < 'h3F00);
  endfunction

  function automatic int ciramIndex(input logic [13:0] a, input logic [1:0] m);
    int av, page;
    av = int'(a);
    case (m)
      2'd0:    page = (av / 2048) % 2;
      2'd1:    page = (av / 1024) % 2;
      2'd2:    page = 0;
      default: page = 1;
    endcase
    return page * 1024 + (av % 1024);
  endfunction

  function automatic logic [13:0] pickAddr();
    logic [13:0] b;
    case ($urandom_range(0, 7))
      0: b = 14'h2000;
      1: b = 14'h2400;
      2: b = 14'h2800;
      3: b = 14'h2C00;
      4: b = 14'h3000;
      5: b = 14'h3400;
      6: b = 14'h3F00;
      default: b = 14'h1000;
    endcase
    return b + 14'($urandom_range(0, 7));
  endfunction

  // Advances the reference by one clock edge using the inputs now being driven.
  task automatic modelEdge();
    bit cpuSlot;
    int idx;
    expAck  = 1'b0;
    expDrop = 1'b0;
    expWe   = 1'b0;
    cpuSlot = 1'b0;
    rstNow  = reset;
    if (reset) begin
      txnPhase = 0;
      schRv[cyc] = 1'b0;
      schRv[cyc+1] = 1'b0;
      curRdata = 8'h00;
      curAddr = 11'h0;
      curDin = 8'h00;
      expRv = 1'b0;
      expRd = 8'h00;
      expBusy = 1'b0;
      return;
    end
    if (txnPhase == 1) begin
      if (!ppu_req || (cyc - latchCyc - 1) == MAX_WAIT) begin
        cpuSlot = 1'b1;
        expDrop = ppu_req;
        if (!inRange(tAddr)) begin
          expAck = 1'b1;
          curRdata = 8'h00;
          txnPhase = 0;
        end else if (tWe) begin
          idx = ciramIndex(tAddr, mirror_mode);
          mem[idx] = tWd;
          curAddr = 11'(idx);
          curDin = tWd;
          expWe = 1'b1;
          expAck = 1'b1;
          txnPhase = 0;
        end else begin
          rdIdx = ciramIndex(tAddr, mirror_mode);
          curAddr = 11'(rdIdx);
          txnPhase = 2;
        end
      end
    end else if (txnPhase == 2) begin
      curRdata = mem[rdIdx];
      expAck = 1'b1;
      txnPhase = 0;
    end else if (cpu_req) begin
      tWe = cpu_we;
      tAddr = cpu_addr;
      tWd = cpu_wdata;
      latchCyc = cyc;
      txnPhase = 1;
    end
    if (ppu_req && !cpuSlot) begin
      schRv[cyc+2] = 1'b1;
      if (inRange(ppu_addr)) begin
        idx = ciramIndex(ppu_addr, mirror_mode);
        curAddr = 11'(idx);
        schRd[cyc+2] = mem[idx];
      end else begin
        schRd[cyc+2] = 8'h00;
      end
    end
    expRv = schRv[cyc];
    expRd = schRd[cyc];
    expBusy = (txnPhase != 0);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkOutput();
    chk("ppu_rvalid", 16'(ppu_rvalid), 16'(expRv));
    if (expRv || rstNow) chk("ppu_rdata", 16'(ppu_rdata), 16'(expRd));
    chk("ppu_dropped", 16'(ppu_dropped), 16'(expDrop));
    chk("cpu_busy", 16'(cpu_busy), 16'(expBusy));
    chk("cpu_ack", 16'(cpu_ack), 16'(expAck));
    chk("cpu_rdata", 16'(cpu_rdata), 16'(curRdata));
    chk("ciram_addr", 16'(ciram_addr), 16'(curAddr));
    chk("ciram_we", 16'(ciram_we), 16'(expWe));
    chk("ciram_din", 16'(ciram_din), 16'(curDin));
  endtask

  // One clock: model the edge, let the DUT take it, then compare just after.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
    cyc++;
    cpu_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus();
  endtask

  task automatic cpuPulse(input logic we, input logic [13:0] a, input logic [7:0] d);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    applyStimulus();
  endtask

  task automatic ppuRead(input logic [13:0] a);
    ppu_req = 1'b1;
    ppu_addr = a;
    applyStimulus();
    ppu_req = 1'b0;
  endtask

  initial begin
    $display("[TB] vram_arbiter bench start");
    reset = 1'b1;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();

    mirror_mode = 2'd1;
    cpuPulse(1'b1, 14'h2000, 8'hA5);
    idle(3);
    ppuRead(14'h2800);
    ppuRead(14'h2400);
    idle(3);
    mirror_mode = 2'd0;
    ppuRead(14'h2400);
    ppuRead(14'h2800);
    idle(3);

    cpuPulse(1'b1, 14'h2123, 8'h3C);
    idle(2);
    cpuPulse(1'b0, 14'h2123, 8'h00);
    idle(3);

    ppu_req = 1'b1;
    ppu_addr = 14'h2000;
    cpuPulse(1'b0, 14'h2123, 8'h00);
    idle(14);
    ppu_req = 1'b0;
    idle(3);

    cpuPulse(1'b1, 14'h3F10, 8'h55);
    idle(2);
    cpuPulse(1'b0, 14'h1000, 8'h00);
    idle(3);
    ppuRead(14'h3F00);
    idle(3);

    cpuPulse(1'b1, 14'h3005, 8'h77);
    idle(2);
    ppuRead(14'h2005);
    idle(2);
    mirror_mode = 2'd3;
    cpuPulse(1'b1, 14'h2405, 8'h99);
    idle(2);
    ppuRead(14'h2005);
    ppuRead(14'h2405);
    ppuRead(14'h2805);
    ppuRead(14'h2C05);
    idle(3);

    mirror_mode = 2'd0;
    cpuPulse(1'b0, 14'h2123, 8'h00);
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    idle(2);
    ppuRead(14'h2123);
    reset = 1'b1;
    applyStimulus();
    idle(2);
    cpuPulse(1'b0, 14'h2123, 8'h00);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      ppu_req = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      ppu_addr = pickAddr();
      cpu_req = ($urandom_range(0, 4) == 0);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = pickAddr();
      cpu_wdata = 8'($urandom);
      if ($urandom_range(0, 39) == 0) mirror_mode = 2'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    ppu_req = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
